q2_sequencer: RTL and testbench
===============================

Name: q2_sequencer

Overview:
Clocked, parametrised control sequencer for the Q2 datapath. It replaces the externally-driven state bits and the write-strobe phase with an internal state register and a WIDTH-cycle bit-serial ALU phase counter. It decodes the same datapath strobes as the Q2 control decoder. It adds front-panel run/step/deposit control. It sits between the front panel, the instruction/data bus and the P/X/A/M/F datapath registers.

Parameters:
WIDTH, 8, datapath word width; the ALU phase lasts WIDTH cycles; dbus_msb is bus bit WIDTH-1.
CNT_W, $clog2(WIDTH), width of the ALU bit counter.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  level; 1 = free-run instructions.
step  in  1  one-cycle pulse; execute exactly one instruction from HALT.
dep  in  1  one-cycle pulse; deposit data switches to M[P], then increment P (HALT only).
op  in  3  opcode bits {op5,op4,op3} from O register.
ind  in  1  indirect bit (op2).
dbus_msb  in  1  data bus bit WIDTH-1 during FETCH.
f  in  1  current flag register value.
x0  in  1  X register bit 0.
alu_cout  in  1  serial ALU carry out.
rdp, rdx, rda, rdm  out  1 each  bus read enables.
wro, wra, wrx, wrp, wrm, wrf  out  1 each  register write enables, sampled by datapath on the edge ending the cycle.
incp  out  1  P increment enable.
xh_sel  out  2  X-high source: 0 dbus, 1 P, 2 zero, 3 shift.
xl_sel  out  1  X-low source: 0 dbus, 1 shift.
fout  out  1  next flag value.
halted  out  1  1 while in HALT.
busy  out  1  1 in any state other than HALT.

Behaviour:
- States: HALT, FETCH, DEREF, LOAD, EXEC, ALU. Every state except ALU lasts exactly one cycle. ALU lasts WIDTH cycles; the bit counter loads WIDTH-1 on entry and decrements each cycle; ALU exits when the counter is 0.
- Transitions:
  - HALT -> FETCH when run=1 or step=1. A step latches a one-shot flag.
  - FETCH -> DEREF if ind, else LOAD if op5=0, else EXEC. The op/ind inputs are the values at the end of FETCH, i.e. O was written this cycle.
  - DEREF -> LOAD if op5=0, else EXEC.
  - LOAD -> EXEC.
  - EXEC -> ALU if op5=0, else end-of-instruction.
  - ALU (count 0) -> end-of-instruction.
  - End-of-instruction -> FETCH if run=1 and no step flag; otherwise HALT, clearing the step flag.
- Opcodes {op5,op4,op3}:
  - 0xx: ALU ops 00 ld, 01 nor, 10 add, 11 shr.
  - 100: no-op.
  - 101: store.
  - 110: jump.
  - 111: jump if f=0.
- Strobes (combinational from the registered state and inputs):
  - FETCH: rdp, wro, incp, wrx. xh_sel = zero if dbus_msb else P; xl_sel = dbus.
  - DEREF/LOAD: rdx, rdm, wrx, xh_sel = dbus, xl_sel = dbus.
  - EXEC: rda, rdx. wrm if op=101. wrp if op=110, or op=111 with f=0. wrf if op5=0, with fout = ~op4 | (op3 & x0), giving ld/nor=1, add=0, shr=x0.
  - ALU: wra, wrx, wrf, xh_sel = shift, xl_sel = shift, fout = alu_cout, rdx, rdm.
  - HALT: all write strobes 0, except on dep: wrm=1 and incp=1 for that one cycle.
  - rdx is 1 in every state except FETCH and HALT. rdm is 1 in every state except EXEC; rdm is also 1 in HALT.
- Reset: state = HALT, counter = 0, step flag = 0. All write enables and incp = 0, halted = 1, busy = 0, xh_sel = 0, xl_sel = 0, fout = 0.
- Reset mid-instruction (any state, including mid-ALU) aborts on that edge; no further strobes are issued.
- Simultaneous events:
  - run deasserted mid-instruction: the instruction completes, then HALT.
  - step while running: ignored.
  - dep outside HALT: ignored.
  - dep and step together in HALT: dep wins and step is dropped.
  - run=1 and dep in HALT: run wins, and no deposit occurs.
- wrp and incp are never asserted in the same cycle.

Decomposition:
- Package q2_pkg:
  - state enum q2_state_t (HALT, FETCH, DEREF, LOAD, EXEC, ALU);
  - opcode constants OP_LD, OP_NOR, OP_ADD, OP_SHR, OP_NOP, OP_ST, OP_JMP, OP_JZ;
  - XH_DBUS, XH_P, XH_ZERO, XH_SHIFT encodings.
- One sub-module, q2_bit_counter: parametrised down-counter with load, enable and zero flag, used for the ALU phase.

Test Plan:
- rst held 2 cycles, then released with run=0 -> halted=1, all write enables 0, state HALT indefinitely.
- WIDTH=8, run=1, op=000, ind=0 -> FETCH, LOAD, EXEC, 8×ALU, FETCH = 11 cycles per instruction. wra high exactly 8 cycles. fout=1 in EXEC, then follows alu_cout.
- op=010 (add), ind=1 -> DEREF inserted, 12 cycles. EXEC fout=0. op=011 with x0=1 -> EXEC fout=1.
- op=111 with f=1 -> no wrp; with f=0 -> wrp for exactly one cycle in EXEC. op=101 -> wrm one cycle in EXEC, no ALU, instruction length 3 cycles.
- From HALT: step pulse -> one full instruction, then halted=1. dep pulse -> wrm=1 and incp=1 for 1 cycle. dep while busy -> no wrm.
- rst asserted on the 4th ALU cycle -> next cycle HALT, wra/wrx/wrf=0. run=1 after release -> fresh FETCH.

Source files
------------

// File: rtl/q2_pkg.sv
// q2_pkg: shared state, opcode and X-source encodings for the Q2 sequencer
package q2_pkg;
  typedef enum logic [2:0] {HALT, FETCH, DEREF, LOAD, EXEC, ALU} q2_state_t;
  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_NOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;
  localparam logic [1:0] XH_DBUS  = 2'd0;
  localparam logic [1:0] XH_P     = 2'd1;
  localparam logic [1:0] XH_ZERO  = 2'd2;
  localparam logic [1:0] XH_SHIFT = 2'd3;
endpackage

// File: rtl/q2_bit_counter.sv
// q2_bit_counter: loadable down-counter timing the bit-serial ALU phase
module q2_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  // load WIDTH-1 on ALU entry, then count down one per serial bit
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= CNT_W'(WIDTH - 1);
    else if (en) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/q2_sequencer.sv
// q2_sequencer: instruction sequencer and strobe decoder for the Q2 datapath
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       dep,
  input  logic [2:0] op,
  input  logic       ind,
  input  logic       dbus_msb,
  input  logic       f,
  input  logic       x0,
  input  logic       alu_cout,
  output logic       rdp,
  output logic       rdx,
  output logic       rda,
  output logic       rdm,
  output logic       wro,
  output logic       wra,
  output logic       wrx,
  output logic       wrp,
  output logic       wrm,
  output logic       wrf,
  output logic       incp,
  output logic [1:0] xh_sel,
  output logic       xl_sel,
  output logic       fout,
  output logic       halted,
  output logic       busy
);
  q2_state_t state, nxt;
  logic step_flag, zero, eoi, dep_ok;
  logic [CNT_W-1:0] count;
  q2_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(state == EXEC && !op[2]), .en(state == ALU),
    .count(count), .zero(zero)
  );
  assign eoi = (state == EXEC && op[2]) || (state == ALU && zero);
  assign dep_ok = state == HALT && dep && !run;
  // state register; a step taken from HALT is remembered until the instruction ends
  always_ff @(posedge clk)
    if (rst) begin
      state <= HALT;
      step_flag <= 1'b0;
    end else begin
      state <= nxt;
      step_flag <= state == HALT ? step && !dep : eoi ? 1'b0 : step_flag;
    end
  // next-state sequencing; deposit suppresses a simultaneous step
  always_comb begin
    nxt = state;
    case (state)
      HALT:  nxt = (run || (step && !dep)) ? FETCH : HALT;
      FETCH: nxt = ind ? DEREF : op[2] ? EXEC : LOAD;
      DEREF: nxt = op[2] ? EXEC : LOAD;
      LOAD:  nxt = EXEC;
      EXEC:  nxt = op[2] ? (run && !step_flag ? FETCH : HALT) : ALU;
      ALU:   nxt = zero ? (run && !step_flag ? FETCH : HALT) : ALU;
      default: nxt = HALT;
    endcase
  end
  // datapath strobes decoded from the registered state and live inputs
  always_comb begin
    rdp    = state == FETCH;
    rdx    = state != FETCH && state != HALT;
    rda    = state == EXEC;
    rdm    = state != EXEC;
    wro    = state == FETCH;
    wra    = state == ALU;
    wrx    = state == FETCH || state == DEREF || state == LOAD || state == ALU;
    wrp    = state == EXEC && (op == OP_JMP || (op == OP_JZ && !f));
    wrm    = (state == EXEC && op == OP_ST) || dep_ok;
    wrf    = (state == EXEC && !op[2]) || state == ALU;
    incp   = state == FETCH || dep_ok;
    xh_sel = state == FETCH ? (dbus_msb ? XH_ZERO : XH_P) : state == ALU ? XH_SHIFT : XH_DBUS;
    xl_sel = state == ALU;
    fout   = state == ALU ? alu_cout : (state == EXEC && !op[2]) ? (!op[1] || (op[0] && x0)) : 1'b0;
    halted = state == HALT;
    busy   = state != HALT;
  end
endmodule

// File: tb/tb_q2_sequencer.sv
// tb_q2_sequencer: directed and randomized checks of q2_sequencer against an instruction-level model
module tb_q2_sequencer;
  localparam int W = 8;
  localparam int PH_H = 0, PH_F = 1, PH_D = 2, PH_L = 3, PH_E = 4, PH_A = 5;
  logic clk = 1'b0;
  logic rst, run, step, dep, ind, dbus_msb, f, x0, alu_cout;
  logic [2:0] op;
  logic rdp, rdx, rda, rdm, wro, wra, wrx, wrp, wrm, wrf, incp, xl_sel, fout, halted, busy;
  logic [1:0] xh_sel;
  logic [16:0] obs;
  int vectors = 0, miscompares = 0;
  q2_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .dep(dep), .op(op), .ind(ind),
    .dbus_msb(dbus_msb), .f(f), .x0(x0), .alu_cout(alu_cout),
    .rdp(rdp), .rdx(rdx), .rda(rda), .rdm(rdm), .wro(wro), .wra(wra), .wrx(wrx),
    .wrp(wrp), .wrm(wrm), .wrf(wrf), .incp(incp), .xh_sel(xh_sel), .xl_sel(xl_sel),
    .fout(fout), .halted(halted), .busy(busy)
  );
  always #5 clk = ~clk;
  assign obs = {rdp, rdx, rda, rdm, wro, wra, wrx, wrp, wrm, wrf, incp, xh_sel, xl_sel, fout, halted, busy};
  function automatic logic [16:0] expect_out(int ph);
    logic e_rdp, e_rdx, e_rda, e_rdm, e_wro, e_wra, e_wrx, e_wrp, e_wrm, e_wrf, e_incp, e_xl, e_fout;
    logic [1:0] e_xh;
    logic deposit, alu_op;
    deposit = ph == PH_H && dep && !run;
    alu_op  = op < 3'd4;
    e_rdp = ph == PH_F;
    e_rdx = !(ph == PH_F || ph == PH_H);
    e_rda = ph == PH_E;
    e_rdm = ph != PH_E;
    e_wro = ph == PH_F;
    e_wra = ph == PH_A;
    e_wrx = ph inside {PH_F, PH_D, PH_L, PH_A};
    e_wrp = ph == PH_E && (op == 3'd6 || (op == 3'd7 && f == 1'b0));
    e_wrm = (ph == PH_E && op == 3'd5) || deposit;
    e_wrf = (ph == PH_E && alu_op) || ph == PH_A;
    e_incp = ph == PH_F || deposit;
    e_xh = 2'd0;
    if (ph == PH_F) e_xh = dbus_msb ? 2'd2 : 2'd1;
    if (ph == PH_A) e_xh = 2'd3;
    e_xl = ph == PH_A;
    e_fout = 1'b0;
    if (ph == PH_A) e_fout = alu_cout;
    if (ph == PH_E && alu_op)
      case (op[1:0])
        2'd0, 2'd1: e_fout = 1'b1;
        2'd2: e_fout = 1'b0;
        default: e_fout = x0;
      endcase
    return {e_rdp, e_rdx, e_rda, e_rdm, e_wro, e_wra, e_wrx, e_wrp, e_wrm, e_wrf, e_incp,
            e_xh, e_xl, e_fout, ph == PH_H, ph != PH_H};
  endfunction
  task automatic check(input string tag, input int ph);
    logic [16:0] e;
    e = expect_out(ph);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask
  task automatic rand_data();
    dbus_msb = 1'($urandom);
    f = 1'($urandom);
    x0 = 1'($urandom);
    alu_cout = 1'($urandom);
  endtask
  task automatic halt_cycle(input string tag, input logic r, input logic s, input logic d);
    @(negedge clk);
    run = r;
    step = s;
    dep = d;
    rand_data();
    #1;
    check(tag, PH_H);
  endtask
  task automatic run_instr(input logic [2:0] o, input logic i, input int stop_at, input int rst_at, input logic rand_run);
    int ph[$];
    ph.push_back(PH_F);
    if (i) ph.push_back(PH_D);
    if (!o[2]) ph.push_back(PH_L);
    ph.push_back(PH_E);
    if (!o[2]) repeat (W) ph.push_back(PH_A);
    foreach (ph[k]) begin
      @(negedge clk);
      op = o;
      ind = i;
      dep = 1'($urandom);
      step = 1'($urandom);
      rand_data();
      if (k == stop_at) run = 1'b0;
      if (rand_run) run = 1'($urandom);
      if (k == rst_at) rst = 1'b1;
      #1;
      check($sformatf("op%0d_ind%0d_cyc%0d", o, i, k), ph[k]);
      if (k == rst_at) break;
    end
  endtask
  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; dep = 1'b0; op = 3'd0; ind = 1'b0;
    dbus_msb = 1'b0; f = 1'b0; x0 = 1'b0; alu_cout = 1'b0;
    @(posedge clk);
    halt_cycle("reset_a", 1'b0, 1'b0, 1'b0);
    halt_cycle("reset_b", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) halt_cycle("idle", 1'b0, 1'b0, 1'b0);
    halt_cycle("go", 1'b1, 1'b0, 1'b0);
    run_instr(3'd0, 1'b0, -1, -1, 1'b0);
    run_instr(3'd2, 1'b1, -1, -1, 1'b0);
    run_instr(3'd3, 1'b0, -1, -1, 1'b0);
    run_instr(3'd7, 1'b0, -1, -1, 1'b0);
    run_instr(3'd7, 1'b1, -1, -1, 1'b0);
    run_instr(3'd5, 1'b1, -1, -1, 1'b0);
    run_instr(3'd6, 1'b0, -1, -1, 1'b0);
    run_instr(3'd4, 1'b0, -1, -1, 1'b0);
    run_instr(3'd1, 1'b1, -1, -1, 1'b0);
    repeat (40) run_instr(3'($urandom), 1'($urandom), -1, -1, 1'b0);
    run_instr(3'($urandom), 1'($urandom), 1, -1, 1'b0);
    halt_cycle("stopped_a", 1'b0, 1'b0, 1'b0);
    halt_cycle("stopped_b", 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      halt_cycle("step", 1'b0, 1'b1, 1'b0);
      run_instr(3'($urandom), 1'($urandom), -1, -1, 1'b1);
      halt_cycle("after_step_a", 1'b0, 1'b0, 1'b0);
      halt_cycle("after_step_b", 1'b0, 1'b0, 1'b0);
    end
    halt_cycle("dep", 1'b0, 1'b0, 1'b1);
    halt_cycle("after_dep", 1'b0, 1'b0, 1'b0);
    halt_cycle("dep_step", 1'b0, 1'b1, 1'b1);
    halt_cycle("step_dropped", 1'b0, 1'b0, 1'b0);
    halt_cycle("run_dep", 1'b1, 1'b0, 1'b1);
    run_instr(3'd0, 1'b0, -1, 6, 1'b0);
    halt_cycle("aborted", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    halt_cycle("post_reset", 1'b0, 1'b0, 1'b0);
    halt_cycle("restart", 1'b1, 1'b0, 1'b0);
    run_instr(3'd0, 1'b0, -1, -1, 1'b0);
    run_instr(3'd2, 1'b0, 2, -1, 1'b0);
    halt_cycle("final", 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
